// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM arbiter for a shared single-ported fixed-latency memory
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              IReq,
    input  logic [ADDR_W-1:0] IAddr,
    output logic [DATA_W-1:0] IRdata,
    output logic              IValid,
    output logic              IStall,
    input  logic              DReq,
    input  logic              DWrite,
    input  logic [ADDR_W-1:0] DAddr,
    input  logic [DATA_W-1:0] DWdata,
    output logic [DATA_W-1:0] DRdata,
    output logic              DValid,
    output logic              DStall,
    output logic              MemEn,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWdata,
    input  logic [DATA_W-1:0] MemRdata
);

    localparam int LAT_W    = $clog2(MEM_LAT + 1);
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } arbState_e;

    arbState_e           state;
    logic [LAT_W-1:0]    latCnt;
    logic [STARVE_W-1:0] starveCnt;
    logic                curWrite;
    logic                grantI;
    logic                grantD;
    logic                starved;

    // Fetch is forced once data has won STARVE_MAX times in a row while fetch waited
    assign starved = IReq && (starveCnt == STARVE_W'(STARVE_MAX));

    // Pick the winner for an access launched from IDLE; data normally has priority
    always_comb begin
        grantI = 1'b0;
        grantD = 1'b0;
        if (state == IDLE) begin
            if (DReq && !starved) begin
                grantD = 1'b1;
            end else if (IReq) begin
                grantI = 1'b1;
            end
        end
    end

    // Stalls follow the requests combinationally and are forced low while in reset
    always_comb begin
        IStall = IReq && !IValid && !Reset;
        DStall = DReq && !DValid && !Reset;
    end

    // Access sequencer: launch, count out the memory latency, capture and signal completion
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            latCnt   <= '0;
            curWrite <= 1'b0;
            MemEn    <= 1'b0;
            MemWe    <= 1'b0;
            MemAddr  <= '0;
            MemWdata <= '0;
            IRdata   <= '0;
            DRdata   <= '0;
            IValid   <= 1'b0;
            DValid   <= 1'b0;
        end else begin
            IValid <= 1'b0;
            DValid <= 1'b0;
            case (state)
                IDLE: begin
                    MemEn <= 1'b0;
                    MemWe <= 1'b0;
                    if (grantD) begin
                        state    <= WAIT_D;
                        MemEn    <= 1'b1;
                        MemWe    <= DWrite;
                        MemAddr  <= DAddr;
                        MemWdata <= DWdata;
                        curWrite <= DWrite;
                        latCnt   <= LAT_W'(MEM_LAT);
                    end else if (grantI) begin
                        state    <= WAIT_I;
                        MemEn    <= 1'b1;
                        MemWe    <= 1'b0;
                        MemAddr  <= IAddr;
                        curWrite <= 1'b0;
                        latCnt   <= LAT_W'(MEM_LAT);
                    end
                end
                WAIT_I, WAIT_D: begin
                    MemEn <= 1'b0;
                    MemWe <= 1'b0;
                    // The strobe cycle itself is latency cycle zero, so counting starts after it
                    if (!MemEn) begin
                        if (latCnt == LAT_W'(1)) begin
                            state  <= IDLE;
                            latCnt <= '0;
                            if (state == WAIT_I) begin
                                IRdata <= MemRdata;
                                IValid <= 1'b1;
                            end else begin
                                if (!curWrite) begin
                                    DRdata <= MemRdata;
                                end
                                DValid <= 1'b1;
                            end
                        end else begin
                            latCnt <= latCnt - LAT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    MemEn <= 1'b0;
                    MemWe <= 1'b0;
                end
            endcase
        end
    end

    // Starvation counter: counts data grants made over a waiting fetch, saturating
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            starveCnt <= '0;
        end else if (!IReq || grantI) begin
            starveCnt <= '0;
        end else if (grantD && (starveCnt != STARVE_W'(STARVE_MAX))) begin
            starveCnt <= starveCnt + STARVE_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    logic              Clock = 1'b0;
    logic              Reset = 1'b1;
    logic              IReq = 1'b0;
    logic [ADDR_W-1:0] IAddr = '0;
    logic [DATA_W-1:0] IRdata;
    logic              IValid;
    logic              IStall;
    logic              DReq = 1'b0;
    logic              DWrite = 1'b0;
    logic [ADDR_W-1:0] DAddr = '0;
    logic [DATA_W-1:0] DWdata = '0;
    logic [DATA_W-1:0] DRdata;
    logic              DValid;
    logic              DStall;
    logic              MemEn;
    logic              MemWe;
    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWdata;
    logic [DATA_W-1:0] MemRdata = '0;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .Clock(Clock), .Reset(Reset),
        .IReq(IReq), .IAddr(IAddr), .IRdata(IRdata), .IValid(IValid), .IStall(IStall),
        .DReq(DReq), .DWrite(DWrite), .DAddr(DAddr), .DWdata(DWdata),
        .DRdata(DRdata), .DValid(DValid), .DStall(DStall),
        .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata),
        .MemRdata(MemRdata)
    );

    always #5 Clock = ~Clock;

    int cycNow = 0;
    always @(posedge Clock) cycNow <= cycNow + 1;

    int nChecks = 0;
    int nFails  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [DATA_W-1:0] wdata;
        int                cyc;
    } memExp_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                cyc;
    } valExp_t;

    memExp_t memQ[$];
    valExp_t iQ[$];
    valExp_t dQ[$];

    // Memory device: reads return data exactly MEM_LAT cycles after the strobe, junk otherwise
    logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
    logic [ADDR_W:0]   rdPipe [MEM_LAT+1];
    initial for (int i = 0; i <= MEM_LAT; i++) rdPipe[i] = '0;

    always @(negedge Clock) begin
        for (int i = MEM_LAT; i > 0; i--) rdPipe[i] = rdPipe[i-1];
        rdPipe[0] = {MemEn && !MemWe, MemAddr};
        if (MemEn && MemWe) mem[MemAddr] = MemWdata;
        if (rdPipe[MEM_LAT][ADDR_W]) begin
            if (mem.exists(rdPipe[MEM_LAT][ADDR_W-1:0])) MemRdata = mem[rdPipe[MEM_LAT][ADDR_W-1:0]];
            else MemRdata = 32'hBAADBAAD;
        end else begin
            MemRdata = 32'hF0F00000 ^ DATA_W'(cycNow);
        end
    end

    // Scoreboard monitor: every strobe and completion pulse is matched against the queues
    always @(negedge Clock) begin
        if (!Reset) begin
            if (MemEn) begin
                if (memQ.size() == 0) check("unexpected MemEn", 64'(1), 64'(0));
                else begin
                    memExp_t me;
                    me = memQ.pop_front();
                    check("MemEn cycle", 64'(cycNow), 64'(me.cyc));
                    check("MemAddr", 64'(MemAddr), 64'(me.addr));
                    check("MemWe", 64'(MemWe), 64'(me.we));
                    if (me.we) check("MemWdata", 64'(MemWdata), 64'(me.wdata));
                end
            end
            if (IValid) begin
                if (iQ.size() == 0) check("unexpected IValid", 64'(1), 64'(0));
                else begin
                    valExp_t ve;
                    ve = iQ.pop_front();
                    check("IValid cycle", 64'(cycNow), 64'(ve.cyc));
                    check("IRdata", 64'(IRdata), 64'(ve.data));
                end
            end
            if (DValid) begin
                if (dQ.size() == 0) check("unexpected DValid", 64'(1), 64'(0));
                else begin
                    valExp_t ve;
                    ve = dQ.pop_front();
                    check("DValid cycle", 64'(cycNow), 64'(ve.cyc));
                    check("DRdata", 64'(DRdata), 64'(ve.data));
                end
            end
        end
    end

    typedef struct {
        logic              isD;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] expData;
    } vec_t;

    vec_t vecs[9];
    int   t0;

    task automatic checkAllZero(input string tag);
        check({tag, " MemEn"}, 64'(MemEn), 64'(0));
        check({tag, " MemWe"}, 64'(MemWe), 64'(0));
        check({tag, " MemAddr"}, 64'(MemAddr), 64'(0));
        check({tag, " MemWdata"}, 64'(MemWdata), 64'(0));
        check({tag, " IRdata"}, 64'(IRdata), 64'(0));
        check({tag, " DRdata"}, 64'(DRdata), 64'(0));
        check({tag, " IValid"}, 64'(IValid), 64'(0));
        check({tag, " DValid"}, 64'(DValid), 64'(0));
        check({tag, " IStall"}, 64'(IStall), 64'(0));
        check({tag, " DStall"}, 64'(DStall), 64'(0));
    endtask

    // Waits for the requested completions, dropping each request in its Valid cycle
    task automatic waitDone(input bit wantI, input bit wantD, input int budget);
        bit iDone;
        bit dDone;
        int n;
        iDone = !wantI;
        dDone = !wantD;
        n = 0;
        while (!(iDone && dDone) && n < budget) begin
            @(negedge Clock);
            n++;
            if (!iDone && IValid) begin iDone = 1'b1; IReq = 1'b0; end
            if (!dDone && DValid) begin dDone = 1'b1; DReq = 1'b0; end
        end
        if (!(iDone && dDone)) begin
            check("completion timeout", 64'(1), 64'(0));
            IReq = 1'b0;
            DReq = 1'b0;
        end
        DWrite = 1'b0;
    endtask

    task automatic issue(input vec_t v);
        @(negedge Clock);
        t0 = cycNow;
        if (v.isD) begin
            DReq = 1'b1; DWrite = v.we; DAddr = v.addr; DWdata = v.wdata;
            memQ.push_back('{addr: v.addr, we: v.we, wdata: v.wdata, cyc: t0 + 1});
            dQ.push_back('{data: v.expData, cyc: t0 + 2 + MEM_LAT});
        end else begin
            IReq = 1'b1; IAddr = v.addr;
            memQ.push_back('{addr: v.addr, we: 1'b0, wdata: '0, cyc: t0 + 1});
            iQ.push_back('{data: v.expData, cyc: t0 + 2 + MEM_LAT});
        end
        waitDone(!v.isD, v.isD, 20);
    endtask

    initial begin
        int nValid;
        mem[32'h100] = 32'hDEADBEEF;
        mem[32'h104] = 32'h0BADF00D;
        mem[32'h200] = 32'hCAFEF00D;

        vecs[0] = '{isD: 1'b0, we: 1'b0, addr: 32'h100, wdata: 32'h0,        expData: 32'hDEADBEEF};
        vecs[1] = '{isD: 1'b1, we: 1'b0, addr: 32'h200, wdata: 32'h0,        expData: 32'hCAFEF00D};
        vecs[2] = '{isD: 1'b1, we: 1'b1, addr: 32'h040, wdata: 32'h12345678, expData: 32'hCAFEF00D};
        vecs[3] = '{isD: 1'b1, we: 1'b0, addr: 32'h040, wdata: 32'h0,        expData: 32'h12345678};
        vecs[4] = '{isD: 1'b0, we: 1'b0, addr: 32'h040, wdata: 32'h0,        expData: 32'h12345678};
        vecs[5] = '{isD: 1'b0, we: 1'b0, addr: 32'h104, wdata: 32'h0,        expData: 32'h0BADF00D};
        vecs[6] = '{isD: 1'b1, we: 1'b1, addr: 32'h200, wdata: 32'h55AA55AA, expData: 32'h12345678};
        vecs[7] = '{isD: 1'b1, we: 1'b0, addr: 32'h200, wdata: 32'h0,        expData: 32'h55AA55AA};
        vecs[8] = '{isD: 1'b0, we: 1'b0, addr: 32'h100, wdata: 32'h0,        expData: 32'hDEADBEEF};

        // Reset state
        @(negedge Clock);
        checkAllZero("reset");
        @(negedge Clock);
        Reset = 1'b0;

        // Single accesses from the table
        foreach (vecs[k]) issue(vecs[k]);

        // Simultaneous requests: data first, fetch after it
        @(negedge Clock);
        t0 = cycNow;
        DReq = 1'b1; DWrite = 1'b0; DAddr = 32'h200;
        IReq = 1'b1; IAddr = 32'h100;
        memQ.push_back('{addr: 32'h200, we: 1'b0, wdata: '0, cyc: t0 + 1});
        memQ.push_back('{addr: 32'h100, we: 1'b0, wdata: '0, cyc: t0 + 5});
        dQ.push_back('{data: 32'h55AA55AA, cyc: t0 + 4});
        iQ.push_back('{data: 32'hDEADBEEF, cyc: t0 + 8});
        #1;
        check("simul IStall", 64'(IStall), 64'(1));
        check("simul DStall", 64'(DStall), 64'(1));
        waitDone(1'b1, 1'b1, 30);

        // Starvation guard: both held, grants D,D,D,D,I,D,D,D,D,I
        @(negedge Clock);
        t0 = cycNow;
        DReq = 1'b1; DWrite = 1'b0; DAddr = 32'h200;
        IReq = 1'b1; IAddr = 32'h104;
        for (int k = 0; k < 10; k++) begin
            bit isI;
            isI = (k == 4) || (k == 9);
            memQ.push_back('{addr: isI ? 32'h104 : 32'h200, we: 1'b0, wdata: '0, cyc: t0 + 1 + 4 * k});
            if (isI) iQ.push_back('{data: 32'h0BADF00D, cyc: t0 + 4 + 4 * k});
            else     dQ.push_back('{data: 32'h55AA55AA, cyc: t0 + 4 + 4 * k});
        end
        nValid = 0;
        for (int n = 0; n < 60 && nValid < 10; n++) begin
            @(negedge Clock);
            if (IValid || DValid) nValid++;
        end
        check("starvation completions", 64'(nValid), 64'(10));
        IReq = 1'b0;
        DReq = 1'b0;

        // Back-to-back fetch with IReq held through the first IValid
        @(negedge Clock);
        t0 = cycNow;
        memQ.push_back('{addr: 32'h100, we: 1'b0, wdata: '0, cyc: t0 + 1});
        memQ.push_back('{addr: 32'h100, we: 1'b0, wdata: '0, cyc: t0 + 5});
        iQ.push_back('{data: 32'hDEADBEEF, cyc: t0 + 4});
        iQ.push_back('{data: 32'hDEADBEEF, cyc: t0 + 8});
        IReq = 1'b1; IAddr = 32'h100;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) @(negedge Clock);
            #1;
            check($sformatf("b2b IStall cyc%0d", k), 64'(IStall), 64'((k == 4 || k == 8) ? 0 : 1));
        end
        IReq = 1'b0;

        // Reset in the middle of a fetch: access abandoned, no IValid
        @(negedge Clock);
        t0 = cycNow;
        IReq = 1'b1; IAddr = 32'h104;
        memQ.push_back('{addr: 32'h104, we: 1'b0, wdata: '0, cyc: t0 + 1});
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        #1;
        checkAllZero("midreset");
        IReq = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        repeat (6) @(negedge Clock);
        issue(vecs[0]);

        repeat (4) @(negedge Clock);
        check("memQ drained", 64'(memQ.size()), 64'(0));
        check("iQ drained", 64'(iQ.size()), 64'(0));
        check("dQ drained", 64'(dQ.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
